// File: rtl/relax_osc_trim_ctrl.sv
// relax_osc_trim_ctrl: SAR calibration of the relaxation-oscillator trim code.
// Counts synchronised osc_in rising edges over a fixed clk gate window and
// binary-searches the trim code for the largest value whose edge count does
// not exceed the programmed target.
// Optional feature macro: RELAX_OSC_TRACK_EN. When it is defined, the block
// keeps measuring after lock and nudges trim by +/-1 to follow drift.
module relax_osc_trim_ctrl #(
  parameter int TRIM_W        = 6,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              osc_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  target,
  output logic [TRIM_W-1:0] trim,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              locked
);
  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int BIT_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  typedef enum logic [2:0] {
    IDLE, SETBIT, SETTLE, MEASURE, DECIDE, DONE, TRACK
  } state_t;

  state_t            state;
  logic [2:0]        osc_sync;
  logic              osc_rise;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [TMR_W-1:0]  tmr;
  logic [BIT_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  target_q;
  logic              trk;
  logic [CNT_W:0]    cnt_x;
  logic [CNT_W:0]    tgt_x;

  // Two flops resynchronise the async oscillator, the third gives the previous level for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) osc_sync <= '0;
    else        osc_sync <= {osc_sync[1:0], osc_in};
  end

  assign osc_rise = osc_sync[1] & ~osc_sync[2];
  // Counter sticks at all-ones instead of wrapping so a fast oscillator never looks slow.
  assign cnt_inc  = (osc_rise && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  // One extra bit so the +/-1 tracking band never overflows at the top of the range.
  assign cnt_x    = {1'b0, count};
  assign tgt_x    = {1'b0, target_q};

  // Calibration sequencer: SAR over trim bits, MSB first, one measurement per bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      trim     <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      locked   <= 1'b0;
      cnt      <= '0;
      tmr      <= '0;
      bit_idx  <= '0;
      target_q <= '0;
      trk      <= 1'b0;
    end else if (!ena) begin
      // Tile disabled: abandon any search but leave the DAC code where it is.
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      locked <= 1'b0;
      trk    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (state == IDLE || trk)) begin
        target_q <= target;
        bit_idx  <= BIT_W'(TRIM_W - 1);
        trim     <= '0;
        busy     <= 1'b1;
        locked   <= 1'b0;
        trk      <= 1'b0;
        state    <= SETBIT;
      end else begin
        case (state)
          IDLE: ;
          SETBIT: begin
            trim[bit_idx] <= 1'b1;
            tmr           <= '0;
            state         <= SETTLE;
          end
          SETTLE: begin
            // Oscillator still slewing to the new code; discard its edges.
            cnt <= '0;
            if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
              tmr   <= '0;
              state <= MEASURE;
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end
          MEASURE: begin
            cnt <= cnt_inc;
            if (tmr == TMR_W'(GATE_CYCLES - 1)) begin
              count <= cnt_inc;
              state <= trk ? TRACK : DECIDE;
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end
          DECIDE: begin
            // Too fast: this bit overshoots the target, back it out.
            if (count > target_q) trim[bit_idx] <= 1'b0;
            if (bit_idx == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              busy   <= 1'b0;
              locked <= 1'b1;
            end else begin
              bit_idx <= bit_idx - BIT_W'(1);
              state   <= SETBIT;
            end
          end
          DONE: begin
`ifdef RELAX_OSC_TRACK_EN
            trk   <= 1'b1;
            tmr   <= '0;
            state <= SETTLE;
`else
            state <= IDLE;
`endif
          end
          TRACK: begin
            // Dead band of +/-1 edge keeps the code from dithering around the target.
            if (cnt_x > tgt_x + (CNT_W+1)'(1)) begin
              if (trim != '0) trim <= trim - TRIM_W'(1);
            end else if (cnt_x + (CNT_W+1)'(1) < tgt_x) begin
              if (trim != '1) trim <= trim + TRIM_W'(1);
            end
            tmr   <= '0;
            state <= SETTLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
